sum_bcd_display: RTL and testbench

- Downstream consumer of the 5-bit adder result.
- Accepts a binary sum over a valid/ready handshake and converts it to two BCD digits with an iterative shift-add-3 (double-dabble) FSM.
- Drives a time-multiplexed, 2-digit, common-anode 7-segment display on the FPGA board.

---
 rtl/sum_bcd_display.sv | 147 ++++++++++++++
 tb/tb_sum_bcd_display.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/sum_bcd_display.sv
// Binary-to-BCD converter (iterative double-dabble) driving a 2-digit multiplexed 7-segment display.
// Define ZERO_BLANK_EN to blank a leading zero in the tens digit.
module sum_bcd_display #(
    parameter int unsigned SUM_W    = 5,
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SUM_W-1:0] sum_in,
    input  logic             sum_valid,
    output logic             sum_ready,
    output logic             busy,
    output logic [3:0]       bcd_tens,
    output logic [3:0]       bcd_ones,
    output logic [6:0]       seg,
    output logic [1:0]       an
);

    localparam int unsigned SHW   = $clog2(SUM_W + 1);
    localparam int unsigned CNT_W = $clog2(SCAN_DIV);
    localparam int unsigned DDW   = 8 + SUM_W;

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e           state_q, state_d;
    logic [SUM_W-1:0] sreg_q, sreg_d;
    logic [7:0]       scratch_q, scratch_d;
    logic [SHW-1:0]   bits_q, bits_d;
    logic [3:0]       tens_q, tens_d;
    logic [3:0]       ones_q, ones_d;
    logic [CNT_W-1:0] scan_q, scan_d;
    logic             sel_q, sel_d;
    logic [1:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic [7:0]       corr;
    logic [DDW-1:0]   dabble;
    logic [6:0]       tens_seg;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'b1111111;
        endcase
    endfunction

    // Conversion FSM
    always_comb begin
        state_d   = state_q;
        sreg_d    = sreg_q;
        scratch_d = scratch_q;
        bits_d    = bits_q;
        tens_d    = tens_q;
        ones_d    = ones_q;
        corr      = scratch_q;
        dabble    = '0;
        unique case (state_q)
            StIdle: begin
                if (sum_valid) begin
                    sreg_d    = sum_in;
                    scratch_d = '0;
                    bits_d    = SHW'(SUM_W);
                    state_d   = StShift;
                end
            end
            StShift: begin
                if (corr[3:0] >= 4'd5) corr[3:0] = corr[3:0] + 4'd3;
                if (corr[7:4] >= 4'd5) corr[7:4] = corr[7:4] + 4'd3;
                dabble    = {corr, sreg_q} << 1;
                scratch_d = dabble[DDW-1:SUM_W];
                sreg_d    = dabble[SUM_W-1:0];
                bits_d    = bits_q - SHW'(1);
                if (bits_q == SHW'(1)) state_d = StDone;
            end
            StDone: begin
                tens_d  = scratch_q[7:4];
                ones_d  = scratch_q[3:0];
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Scan and display; an/seg follow next-state sel/bcd so they stay aligned with the registers.
    always_comb begin
        scan_d = scan_q + CNT_W'(1);
        sel_d  = sel_q;
        if (scan_q == CNT_W'(SCAN_DIV - 1)) begin
            scan_d = '0;
            sel_d  = ~sel_q;
        end
`ifdef ZERO_BLANK_EN
        tens_seg = (tens_d == 4'd0) ? 7'b1111111 : decode(tens_d);
`else
        tens_seg = decode(tens_d);
`endif
        if (sel_d) begin
            an_d  = 2'b01;
            seg_d = tens_seg;
        end else begin
            an_d  = 2'b10;
            seg_d = decode(ones_d);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            sreg_q    <= '0;
            scratch_q <= '0;
            bits_q    <= '0;
            tens_q    <= '0;
            ones_q    <= '0;
            scan_q    <= '0;
            sel_q     <= 1'b0;
            an_q      <= 2'b10;
            seg_q     <= 7'b1000000;
        end else begin
            state_q   <= state_d;
            sreg_q    <= sreg_d;
            scratch_q <= scratch_d;
            bits_q    <= bits_d;
            tens_q    <= tens_d;
            ones_q    <= ones_d;
            scan_q    <= scan_d;
            sel_q     <= sel_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
        end
    end

    assign sum_ready = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign bcd_tens  = tens_q;
    assign bcd_ones  = ones_q;
    assign an        = an_q;
    assign seg       = seg_q;

endmodule

// File: tb/tb_sum_bcd_display.sv
// Scoreboard bench for sum_bcd_display: expected digits queued on accept, checked on completion.
module tb_sum_bcd_display;

    localparam int SUM_W    = 5;
    localparam int SCAN_DIV = 4;
    localparam int LAT      = SUM_W + 1;

    logic             clk;
    logic             clk_en;
    logic             rst_n;
    logic [SUM_W-1:0] sum_in;
    logic             sum_valid;
    logic             sum_ready;
    logic             busy;
    logic [3:0]       bcd_tens;
    logic [3:0]       bcd_ones;
    logic [6:0]       seg;
    logic [1:0]       an;

    sum_bcd_display #(
        .SUM_W    (SUM_W),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sum_in    (sum_in),
        .sum_valid (sum_valid),
        .sum_ready (sum_ready),
        .busy      (busy),
        .bcd_tens  (bcd_tens),
        .bcd_ones  (bcd_ones),
        .seg       (seg),
        .an        (an)
    );

    typedef struct {
        logic [3:0] tens;
        logic [3:0] ones;
        int         acc_cyc;
    } exp_t;

    exp_t       sb_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    int         m_scan  = 0;
    logic       m_sel   = 1'b0;
    logic [3:0] m_tens  = 4'd0;
    logic [3:0] m_ones  = 4'd0;
    logic       prev_busy = 1'b0;

    always #5 if (clk_en) clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_scan <= 0;
            m_sel  <= 1'b0;
        end else if (m_scan == SCAN_DIV - 1) begin
            m_scan <= 0;
            m_sel  <= ~m_sel;
        end else begin
            m_scan <= m_scan + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] tbl [10];
        tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        return (d < 4'd10) ? tbl[d] : 7'b1111111;
    endfunction

    function automatic logic [6:0] tens_seg_of(input logic [3:0] d);
`ifdef ZERO_BLANK_EN
        if (d == 4'd0) return 7'b1111111;
`endif
        return seg_of(d);
    endfunction

    // Monitor: completion, prior-value stability, and scan/display against the model.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            sb_q.delete();
            m_tens    = 4'd0;
            m_ones    = 4'd0;
            prev_busy = 1'b0;
        end else begin
            if (prev_busy && sum_ready) begin
                if (sb_q.size() == 0) begin
                    check("done_without_accept", sb_q.size(), 1);
                end else begin
                    e = sb_q.pop_front();
                    check("result_tens", bcd_tens, e.tens);
                    check("result_ones", bcd_ones, e.ones);
                    check("latency", cyc - e.acc_cyc, LAT);
                    m_tens = e.tens;
                    m_ones = e.ones;
                end
            end
            if (sum_valid && sum_ready) begin
                e.tens    = 4'(sum_in / 10);
                e.ones    = 4'(sum_in % 10);
                e.acc_cyc = cyc + 1;
                sb_q.push_back(e);
            end
            check("bcd_tens_held", bcd_tens, m_tens);
            check("bcd_ones_held", bcd_ones, m_ones);
            check("an", an, m_sel ? 2'b01 : 2'b10);
            check("seg", seg, m_sel ? tens_seg_of(m_tens) : seg_of(m_ones));
            prev_busy = busy;
        end
    end

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic send(input logic [SUM_W-1:0] v, input bit hold, input bit noisy,
                        output int acc);
        int n = 0;
        sum_valid = 1'b1;
        while (!sum_ready && n < 50) begin
            sum_in = noisy ? SUM_W'($urandom) : v;
            @(posedge clk);
            #1;
            n++;
        end
        check("accept_timeout", n < 50, 1);
        sum_in = v;
        acc    = cyc + 1;
        @(posedge clk);
        #1;
        check("ready_drops", sum_ready, 0);
        if (!hold) sum_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, sum_ready, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_tens"}, bcd_tens, 0);
        check({tag, "_ones"}, bcd_ones, 0);
        check({tag, "_an"}, an, 2'b10);
        check({tag, "_seg"}, seg, 7'b1000000);
    endtask

    task automatic drain();
        int n = 0;
        while ((sb_q.size() != 0 || !sum_ready) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_timeout", n < 100, 1);
        repeat (10) @(posedge clk);
        #1;
    endtask

    initial begin
        int a1, a2;
        clk       = 1'b0;
        clk_en    = 1'b1;
        rst_n     = 1'b0;
        sum_valid = 1'b0;
        sum_in    = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("rst");
        @(posedge clk);
        #1;

        // 27 -> 2/7
        send(5'd27, 1'b0, 1'b0, a1);
        drain();

        // 31 then 0 back-to-back, valid held throughout
        send(5'd31, 1'b1, 1'b0, a1);
        send(5'd0, 1'b0, 1'b0, a2);
        check("b2b_gap", a2 - a1, LAT + 1);
        drain();

        // sum_in wiggles while busy; only the value at the ready cycle counts
        send(5'd10, 1'b1, 1'b0, a1);
        send(5'd22, 1'b0, 1'b1, a2);
        drain();

        // 9 -> tens blank or 0 depending on build
        send(5'd9, 1'b0, 1'b0, a1);
        drain();

        // Reset during the third SHIFT cycle of 18, with the clock stopped
        send(5'd18, 1'b0, 1'b0, a1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("busy_before_abort", busy, 1);
        clk_en = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        clk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(5'd5, 1'b0, 1'b0, a1);
        drain();

        check("scoreboard_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
